// File: rtl/alu_ctrl_pkg.sv
// ALU_CTRL encodings shared by EX-stage units, the multiply/divide range helper
// and the muldiv sequencer state type.
package alu_ctrl_pkg;

    localparam int ALU_CTRL_W = 5;

    localparam logic [ALU_CTRL_W-1:0] AND     = 5'b00000;
    localparam logic [ALU_CTRL_W-1:0] OR      = 5'b00001;
    localparam logic [ALU_CTRL_W-1:0] ADD     = 5'b00010;
    localparam logic [ALU_CTRL_W-1:0] XOR     = 5'b00011;
    localparam logic [ALU_CTRL_W-1:0] SLL     = 5'b00100;
    localparam logic [ALU_CTRL_W-1:0] SRL     = 5'b00101;
    localparam logic [ALU_CTRL_W-1:0] SUB     = 5'b00110;
    localparam logic [ALU_CTRL_W-1:0] SRA     = 5'b00111;
    localparam logic [ALU_CTRL_W-1:0] SLT     = 5'b01000;
    localparam logic [ALU_CTRL_W-1:0] SLTU    = 5'b01001;
    localparam logic [ALU_CTRL_W-1:0] MUL     = 5'b01010;
    localparam logic [ALU_CTRL_W-1:0] MULH    = 5'b01011;
    localparam logic [ALU_CTRL_W-1:0] MULHSU  = 5'b01100;
    localparam logic [ALU_CTRL_W-1:0] MULHU   = 5'b01101;
    localparam logic [ALU_CTRL_W-1:0] DIV     = 5'b01110;
    localparam logic [ALU_CTRL_W-1:0] DIVU    = 5'b01111;
    localparam logic [ALU_CTRL_W-1:0] REM     = 5'b10000;
    localparam logic [ALU_CTRL_W-1:0] REMU    = 5'b10001;
    localparam logic [ALU_CTRL_W-1:0] LUI     = 5'b10010;
    localparam logic [ALU_CTRL_W-1:0] INVALID = 5'b11111;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_t;

    function automatic logic is_md(input logic [ALU_CTRL_W-1:0] code);
        return (code >= MUL) && (code <= REMU);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per step_i.
// acc_o holds {hi,lo} of the product, or {remainder,quotient} after XLEN steps.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   opa_i,
    input  logic [XLEN-1:0]   opb_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q;
    logic              is_div_q;
    logic [XLEN:0]     add_sum, shl;
    logic [XLEN-1:0]   sub_diff;
    logic              fits;

    always_comb begin
        add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        shl      = acc_q[2*XLEN-1:XLEN-1];
        fits     = (shl >= {1'b0, opb_q});
        // when the trial subtract fits, the difference is below the divisor and fits XLEN bits
        sub_diff = shl[XLEN-1:0] - opb_q;
        if (is_div_q) begin
            acc_d = fits ? {sub_diff, acc_q[XLEN-2:0], 1'b1}
                         : {shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            acc_d = {add_sum, acc_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
        end else if (load_i) begin
            acc_q    <= {{XLEN{1'b0}}, opa_i};
            opb_q    <= opb_i;
            is_div_q <= is_div_i;
        end else if (step_i) begin
            acc_q    <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle engine: XLEN+2 cycles (divide-by-zero/overflow in 1), stalls EX until the
// one-cycle RESULT_VALID. MULDIV_FAST_MUL_EN selects a single-cycle combinational multiply.
module muldiv_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 5
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [CTRL_W-1:0] ALU_CTRL,
    input  logic              OP_VALID,
    input  logic [XLEN-1:0]   DATA1,
    input  logic [XLEN-1:0]   DATA2,
    input  logic              FLUSH,
    output logic              STALL,
    output logic              BUSY,
    output logic [XLEN-1:0]   RESULT,
    output logic              RESULT_VALID
);

    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state_q;
    logic [CTRL_W-1:0] op_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;
    logic              result_vld_q;

    logic              is_md_w, accept, rem_op, div_op, sgn_a, sgn_b, neg_d;
    logic              div_zero, div_ovf, special, fast_hit, core_load;
    logic [XLEN-1:0]   abs_a, abs_b, spec_res, fast_res, word, fix_res;
    logic [2*XLEN-1:0] acc, prod;

    always_comb begin
        is_md_w  = is_md(ALU_CTRL);
        accept   = (state_q == IDLE) && OP_VALID && is_md_w && !FLUSH;
        rem_op   = (ALU_CTRL == REM) || (ALU_CTRL == REMU);
        div_op   = (ALU_CTRL == DIV) || (ALU_CTRL == DIVU) || rem_op;
        sgn_a    = ((ALU_CTRL == MULH) || (ALU_CTRL == MULHSU) || (ALU_CTRL == DIV)
                    || (ALU_CTRL == REM)) && DATA1[XLEN-1];
        sgn_b    = ((ALU_CTRL == MULH) || (ALU_CTRL == DIV) || (ALU_CTRL == REM))
                   && DATA2[XLEN-1];
        abs_a    = sgn_a ? ('0 - DATA1) : DATA1;
        abs_b    = sgn_b ? ('0 - DATA2) : DATA2;
        neg_d    = rem_op ? sgn_a : (sgn_a ^ sgn_b);
        div_zero = div_op && (DATA2 == '0);
        div_ovf  = ((ALU_CTRL == DIV) || (ALU_CTRL == REM)) && (DATA1 == INT_MIN) && (DATA2 == '1);
        special  = div_zero || div_ovf;
        spec_res = div_zero ? (rem_op ? DATA1 : '1) : (rem_op ? '0 : INT_MIN);
        core_load = accept && !special && !fast_hit;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    always_comb begin
        fast_prod = {{XLEN{sgn_a}}, DATA1} * {{XLEN{sgn_b}}, DATA2};
        fast_hit  = !div_op;
        fast_res  = (ALU_CTRL == MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk_i    (CLK),
        .rst_ni   (RESET_N),
        .load_i   (core_load),
        .step_i   (state_q == CALC),
        .is_div_i (div_op),
        .opa_i    (abs_a),
        .opb_i    (abs_b),
        .acc_o    (acc)
    );

    // Sign correction on the unsigned magnitude result, then word selection
    always_comb begin
        prod = neg_q ? ('0 - acc) : acc;
        word = ((op_q == REM) || (op_q == REMU)) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (op_q >= DIV) begin
            fix_res = neg_q ? ('0 - word) : word;
        end else begin
            fix_res = (op_q == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            op_q         <= '0;
            neg_q        <= 1'b0;
            cnt_q        <= '0;
            result_q     <= '0;
            result_vld_q <= 1'b0;
        end else begin
            result_vld_q <= 1'b0;
            if (FLUSH) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (accept) begin
                        op_q  <= ALU_CTRL;
                        neg_q <= neg_d;
                        cnt_q <= CNT_W'(XLEN-1);
                        if (special || fast_hit) begin
                            result_q     <= special ? spec_res : fast_res;
                            result_vld_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                    CALC: begin
                        if (cnt_q == '0) state_q <= FIX;
                        else             cnt_q   <= cnt_q - 1'b1;
                    end
                    FIX: begin
                        result_q     <= fix_res;
                        result_vld_q <= 1'b1;
                        state_q      <= DONE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign STALL        = OP_VALID && is_md_w && (state_q != DONE);
    assign BUSY         = (state_q != IDLE);
    assign RESULT       = result_q;
    assign RESULT_VALID = result_vld_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus flush, reset and back-to-back sequences.
module tb_muldiv_sequencer;
    import alu_ctrl_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [4:0]  ALU_CTRL = ADD;
    logic        OP_VALID = 1'b0;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic        FLUSH = 1'b0;
    logic        STALL, BUSY, RESULT_VALID;
    logic [31:0] RESULT;

    int n_chk  = 0;
    int n_fail = 0;

    muldiv_sequencer dut (
        .CLK(CLK), .RESET_N(RESET_N), .ALU_CTRL(ALU_CTRL), .OP_VALID(OP_VALID),
        .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH), .STALL(STALL), .BUSY(BUSY),
        .RESULT(RESULT), .RESULT_VALID(RESULT_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op in IDLE and wait (bounded) for its RESULT_VALID; lat stays -1 on timeout.
    task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stall_err);
        @(posedge CLK); #1;
        ALU_CTRL = c; DATA1 = a; DATA2 = b; OP_VALID = 1'b1;
        #1;
        stall_err = (STALL !== 1'b1) ? 1 : 0;
        lat = -1;
        res = '0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge CLK); #1;
            if (RESULT_VALID === 1'b1) begin
                lat = k;
                res = RESULT;
                if (STALL !== 1'b0) stall_err++;
                break;
            end else if (STALL !== 1'b1) begin
                stall_err++;
            end
        end
        OP_VALID = 1'b0;
        ALU_CTRL = ADD;
    endtask

    typedef struct {
        string       name;
        logic [4:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t        vecs[14];
    logic [31:0] r, r1, r2, saved;
    int          lat, serr, pulses, first, second;

    initial begin
        vecs[0]  = '{"mul_7xm3",     MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
        vecs[1]  = '{"mul_m1xm1",    MUL,    32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001, MUL_LAT};
        vecs[2]  = '{"mulh_min_sq",  MULH,   32'h80000000,   32'h80000000, 32'h40000000, MUL_LAT};
        vecs[3]  = '{"mulhu_max_sq", MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
        vecs[4]  = '{"mulhsu_m1",    MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT};
        vecs[5]  = '{"div_m7_2",     DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, DIV_LAT};
        vecs[6]  = '{"rem_m7_2",     REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, DIV_LAT};
        vecs[7]  = '{"divu_100_7",   DIVU,   32'd100,        32'd7,        32'd14,       DIV_LAT};
        vecs[8]  = '{"remu_100_7",   REMU,   32'd100,        32'd7,        32'd2,        DIV_LAT};
        vecs[9]  = '{"div_5_0",      DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 1};
        vecs[10] = '{"rem_5_0",      REM,    32'd5,          32'd0,        32'd5,        1};
        vecs[11] = '{"div_ovf",      DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
        vecs[12] = '{"rem_ovf",      REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
        vecs[13] = '{"divu_big_0",   DIVU,   32'h12345678,   32'd0,        32'hFFFFFFFF, 1};

        #12 RESET_N = 1'b1;
        #1;
        check("reset_busy",   {31'd0, BUSY}, 32'd0);
        check("reset_result", RESULT, 32'd0);
        check("reset_valid",  {31'd0, RESULT_VALID}, 32'd0);
        check("reset_stall",  {31'd0, STALL}, 32'd0);

        // Non-muldiv code must be ignored
        @(posedge CLK); #1;
        ALU_CTRL = ADD; DATA1 = 32'd3; DATA2 = 32'd4; OP_VALID = 1'b1;
        #1;
        check("add_stall", {31'd0, STALL}, 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        check("add_busy", {31'd0, BUSY}, 32'd0);
        OP_VALID = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].ctrl, vecs[i].d1, vecs[i].d2, r, lat, serr);
            check({vecs[i].name, "_result"}, r, vecs[i].res);
            check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
            check({vecs[i].name, "_stall"}, serr, 0);
            @(posedge CLK); #1;
            check({vecs[i].name, "_pulse_once"}, {31'd0, RESULT_VALID}, 32'd0);
            check({vecs[i].name, "_hold"}, RESULT, vecs[i].res);
        end

        // Flush a DIV in cycle 10
        saved = RESULT;
        @(posedge CLK); #1;
        ALU_CTRL = DIV; DATA1 = 32'd1000; DATA2 = 32'd3; OP_VALID = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check("flush_busy_before", {31'd0, BUSY}, 32'd1);
        FLUSH = 1'b1; OP_VALID = 1'b0;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        check("flush_idle", {31'd0, BUSY}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK); #1;
            if (RESULT_VALID === 1'b1) pulses++;
        end
        check("flush_no_pulse", pulses, 0);
        check("flush_result_kept", RESULT, saved);

        // FLUSH together with a would-be accept
        @(posedge CLK); #1;
        ALU_CTRL = DIVU; DATA1 = 32'd50; DATA2 = 32'd5; OP_VALID = 1'b1; FLUSH = 1'b1;
        @(posedge CLK); #1;
        check("flush_beats_accept", {31'd0, BUSY}, 32'd0);
        FLUSH = 1'b0; OP_VALID = 1'b0;

        // Back-to-back MUL then DIVU; DIVU is presented once the MUL result appears
        first = -1; second = -1; r1 = '0; r2 = '0;
        @(posedge CLK); #1;
        ALU_CTRL = MUL; DATA1 = 32'd7; DATA2 = 32'hFFFFFFFD; OP_VALID = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            @(posedge CLK); #1;
            if (RESULT_VALID === 1'b1) begin
                if (first < 0) begin
                    first = k; r1 = RESULT;
                    ALU_CTRL = DIVU; DATA1 = 32'd100; DATA2 = 32'd7;
                end else begin
                    second = k; r2 = RESULT;
                    break;
                end
            end
        end
        OP_VALID = 1'b0; ALU_CTRL = ADD;
        check("b2b_first_cycle",  first,  MUL_LAT);
        check("b2b_first_result", r1, 32'hFFFFFFEB);
        check("b2b_second_cycle", second, MUL_LAT + 1 + DIV_LAT);
        check("b2b_second_result", r2, 32'd14);

        // Asynchronous reset in cycle 5 of an op
        @(posedge CLK); #1;
        ALU_CTRL = DIVU; DATA1 = 32'd77; DATA2 = 32'd5; OP_VALID = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        #1;
        check("async_reset_busy",   {31'd0, BUSY}, 32'd0);
        check("async_reset_result", RESULT, 32'd0);
        OP_VALID = 1'b0;
        @(posedge CLK); #1;
        RESET_N = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
